// File: rtl/stg_pkg.sv
// Shared playfield constants, FSM state encoding and delta helpers for the
// STG enemy controllers.
package stg_pkg;

    localparam int MAX_X   = 384;
    localparam int MAX_Y   = 448;
    localparam int COORD_W = 10;
    localparam int DELTA_W = 11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_AIM      = 2'd1;
    localparam logic [1:0] ST_DASH     = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic [COORD_W-1:0]        coord_t;

    // Signed distance from b to a; both coordinates fit in 10 bits so 11 bits never overflow.
    function automatic delta_t coord_delta(input coord_t a, input coord_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Magnitude of a delta; |-1023| still fits in 11 unsigned bits.
    function automatic logic [DELTA_W-1:0] delta_abs(input delta_t d);
        return d[DELTA_W-1] ? DELTA_W'(-d) : DELTA_W'(d);
    endfunction

    // Unit step toward the sign of a delta: -1, 0 or +1.
    function automatic delta_t delta_sign(input delta_t d);
        if (d == '0) begin
            return '0;
        end else if (d[DELTA_W-1]) begin
            return -11'sd1;
        end else begin
            return 11'sd1;
        end
    endfunction

endpackage

// File: rtl/moon_line_stepper.sv
// Divider-free Bresenham unit-step engine for the moon dash. A start pulse
// performs the first unit step on the same clock edge and the remaining steps
// of the burst on following edges. Every step is checked against the
// playfield border first; a step that would leave the field is not taken,
// the burst is abandoned and hit_border is raised for that cycle.
module moon_line_stepper #(
    parameter int MAX_X  = stg_pkg::MAX_X,
    parameter int MAX_Y  = stg_pkg::MAX_Y,
    parameter int HOME_X = 192,
    parameter int HOME_Y = 100,
    parameter int LEN_W  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              load,
    input  logic                              go_home,
    input  logic signed [stg_pkg::DELTA_W-1:0] dx,
    input  logic signed [stg_pkg::DELTA_W-1:0] dy,
    input  logic [LEN_W-1:0]                  burst_len,
    output logic [stg_pkg::COORD_W-1:0]       pos_x,
    output logic [stg_pkg::COORD_W-1:0]       pos_y,
    output logic                              busy,
    output logic                              hit_border
);
    import stg_pkg::*;

    localparam logic signed [DELTA_W-1:0] LIM_X = DELTA_W'(MAX_X - 1);
    localparam logic signed [DELTA_W-1:0] LIM_Y = DELTA_W'(MAX_Y - 1);

    coord_t              pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    delta_t              dx_q, dx_d, dy_q, dy_d;
    logic [DELTA_W-1:0]  err_q, err_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                busy_q, busy_d;

    delta_t              vec_dx, vec_dy, step_x, step_y, next_x, next_y;
    logic [DELTA_W-1:0]  err_base, abs_x, abs_y, major_abs, minor_abs, err_sum, err_next;
    logic [LEN_W-1:0]    len_now;
    logic                x_major, minor_step, step_en, out_x, out_y, hit;

    // Candidate unit step: a freshly loaded vector takes effect immediately with a cleared error.
    always_comb begin
        vec_dx     = load ? dx : dx_q;
        vec_dy     = load ? dy : dy_q;
        err_base   = load ? '0 : err_q;
        abs_x      = delta_abs(vec_dx);
        abs_y      = delta_abs(vec_dy);
        x_major    = (abs_x >= abs_y);
        major_abs  = x_major ? abs_x : abs_y;
        minor_abs  = x_major ? abs_y : abs_x;
        err_sum    = err_base + minor_abs;
        minor_step = (err_sum >= major_abs);
        err_next   = minor_step ? (err_sum - major_abs) : err_sum;
        step_x     = (x_major || minor_step) ? delta_sign(vec_dx) : '0;
        step_y     = (!x_major || minor_step) ? delta_sign(vec_dy) : '0;
        next_x     = $signed({1'b0, pos_x_q}) + step_x;
        next_y     = $signed({1'b0, pos_y_q}) + step_y;
        out_x      = next_x[DELTA_W-1] || (next_x > LIM_X);
        out_y      = next_y[DELTA_W-1] || (next_y > LIM_Y);
        step_en    = busy_q || (start && (burst_len != '0));
        len_now    = busy_q ? rem_q : burst_len;
        hit        = step_en && (out_x || out_y);
    end

    // Next-state for position, latched vector, error and burst bookkeeping.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        if (load) begin
            dx_d  = dx;
            dy_d  = dy;
            err_d = '0;
        end
        if (step_en) begin
            if (hit) begin
                busy_d = 1'b0;
                rem_d  = '0;
            end else begin
                pos_x_d = next_x[COORD_W-1:0];
                pos_y_d = next_y[COORD_W-1:0];
                err_d   = err_next;
                rem_d   = len_now - 1'b1;
                busy_d  = (len_now > 1);
            end
        end
        if (go_home) begin
            pos_x_d = COORD_W'(HOME_X);
            pos_y_d = COORD_W'(HOME_Y);
            busy_d  = 1'b0;
            rem_d   = '0;
        end
    end

    // Stepper state registers; reset parks the moon at home with no burst pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_x_q <= COORD_W'(HOME_X);
            pos_y_q <= COORD_W'(HOME_Y);
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign busy       = busy_q;
    assign hit_border = hit;

endmodule

// File: rtl/moon_dash_ctrl.sv
// Moon enemy dash-attack sequencer: speed-scaled movement tick, aim/dash/
// cooldown FSM, and the moon centre position for the renderer and collision.
// Optional build macro MOON_HOMING_EN: while dashing, every 4th tick re-aims
// at the player from the current position (homing arc) before its burst.
module moon_dash_ctrl #(
    parameter int MAX_X    = stg_pkg::MAX_X,
    parameter int MAX_Y    = stg_pkg::MAX_Y,
    parameter int HOME_X   = 192,
    parameter int HOME_Y   = 100,
    parameter int TICK_MAX = 4000,
    parameter int STEP     = 10,
    parameter int COOLDOWN = 200
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [stg_pkg::COORD_W-1:0] player_x,
    input  logic [stg_pkg::COORD_W-1:0] player_y,
    input  logic [25:0]                 speed_offset,
    output logic [stg_pkg::COORD_W-1:0] moon_x,
    output logic [stg_pkg::COORD_W-1:0] moon_y,
    output logic [1:0]                  state_o,
    output logic                        tick_o,
    output logic                        dash_done
);
    import stg_pkg::*;

    localparam int CD_W  = 16;
    localparam int LEN_W = 8;

    logic [25:0]     cnt_q, cnt_d, period, period_m1;
    logic [26:0]     off_ext;
    logic [1:0]      state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d, cd_inc;
    logic            dash_done_q, dash_done_d;
    logic            tick, start, load, go_home, busy, hit, relatch_zero, fresh_zero;
    delta_t          fresh_dx, fresh_dy;
    coord_t          pos_x, pos_y;
`ifdef MOON_HOMING_EN
    logic [1:0]      hcnt_q, hcnt_d;
`endif

    // Tick period with a floor that always leaves room for a full burst.
    always_comb begin
        off_ext = {1'b0, speed_offset};
        if (off_ext + 27'(STEP + 2) > 27'(TICK_MAX)) begin
            period = 26'(STEP + 2);
        end else begin
            period = 26'(TICK_MAX) - speed_offset;
        end
        period_m1 = period - 26'd1;
        tick      = (cnt_q == period_m1);
        // A shrinking period can leave the count past the new end: wrap silently.
        cnt_d     = (cnt_q >= period_m1) ? '0 : cnt_q + 26'd1;
    end

    // Aim vector from the current position toward the player.
    always_comb begin
        fresh_dx   = coord_delta(player_x, pos_x);
        fresh_dy   = coord_delta(player_y, pos_y);
        fresh_zero = (fresh_dx == '0) && (fresh_dy == '0);
        cd_inc     = cd_q + CD_W'(1);
    end

    // Stepper commands: latch the aim in AIM, launch a burst on each free tick in DASH.
    always_comb begin
        start        = 1'b0;
        load         = 1'b0;
        relatch_zero = 1'b0;
`ifdef MOON_HOMING_EN
        hcnt_d       = hcnt_q;
`endif
        if (state_q == ST_AIM) begin
            load = 1'b1;
`ifdef MOON_HOMING_EN
            hcnt_d = '0;
`endif
        end else if ((state_q == ST_DASH) && tick && !busy) begin
`ifdef MOON_HOMING_EN
            hcnt_d = hcnt_q + 2'd1;
            if (hcnt_q == 2'd3) begin
                load         = 1'b1;
                relatch_zero = fresh_zero;
                start        = !fresh_zero;
            end else begin
                start = 1'b1;
            end
`else
            start = 1'b1;
`endif
        end
    end

    // Attack FSM and cooldown counting.
    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        dash_done_d = 1'b0;
        go_home     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_AIM;
                end
            end
            ST_AIM: begin
                cd_d    = '0;
                state_d = fresh_zero ? ST_COOLDOWN : ST_DASH;
            end
            ST_DASH: begin
                if (hit) begin
                    dash_done_d = 1'b1;
                    state_d     = ST_COOLDOWN;
                    cd_d        = '0;
                end else if (relatch_zero) begin
                    state_d = ST_COOLDOWN;
                    cd_d    = '0;
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cd_inc == CD_W'(COOLDOWN)) begin
                        cd_d = '0;
                        if (enable) begin
                            state_d = ST_AIM;
                        end else begin
                            state_d = ST_IDLE;
                            go_home = 1'b1;
                        end
                    end else begin
                        cd_d = cd_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            cd_q        <= '0;
            dash_done_q <= 1'b0;
`ifdef MOON_HOMING_EN
            hcnt_q      <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            cd_q        <= cd_d;
            dash_done_q <= dash_done_d;
`ifdef MOON_HOMING_EN
            hcnt_q      <= hcnt_d;
`endif
        end
    end

    moon_line_stepper #(
        .MAX_X  (MAX_X),
        .MAX_Y  (MAX_Y),
        .HOME_X (HOME_X),
        .HOME_Y (HOME_Y),
        .LEN_W  (LEN_W)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load       (load),
        .go_home    (go_home),
        .dx         (fresh_dx),
        .dy         (fresh_dy),
        .burst_len  (LEN_W'(STEP)),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .hit_border (hit)
    );

    assign moon_x    = pos_x;
    assign moon_y    = pos_y;
    assign state_o   = state_q;
    assign tick_o    = tick;
    assign dash_done = dash_done_q;

endmodule
